// File: rtl/outport_link_tx.sv
// Output-port link transmitter: two single-entry VC buffers filled from the crossbar and
// drained onto the inter-router link in each VC's external phase. Optional macro: HOP_UPDATE_EN.
module outport_link_tx #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned HOP_LSB = 48,
    parameter int unsigned HOP_W   = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic [1:0]        enq,
    input  logic [DATA_W-1:0] d_in,
    output logic [1:0]        full,
    input  logic              link_ri,
    output logic              link_so,
    output logic [DATA_W-1:0] link_do,
    output logic              err_ovf,
    output logic [CNT_W-1:0]  tx_cnt
);

    if (HOP_LSB + HOP_W > DATA_W) begin : g_hop_range
        $error("hop field does not fit inside DATA_W");
    end

    logic [DATA_W-1:0] r_buf [2];
    logic [1:0]        r_full;
    logic              r_so;
    logic [DATA_W-1:0] r_do;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_tx_vc;
    logic [1:0]        w_int_mask;
    logic [1:0]        w_acc;
    logic              w_err;
    logic              w_send;
    logic [1:0]        w_send_mask;
    logic [DATA_W-1:0] w_buf_sel;
    logic [DATA_W-1:0] w_tx_data;

    // VC polarity is internal (may enqueue); VC ~polarity is external (may transmit).
    assign w_tx_vc     = ~polarity;
    assign w_int_mask  = {polarity, ~polarity};
    assign w_acc       = enq & w_int_mask & ~r_full;
    assign w_err       = (|(enq & ~w_int_mask)) | (|(enq & w_int_mask & r_full));
    assign w_send      = r_full[w_tx_vc] & link_ri;
    assign w_send_mask = {2{w_send}} & ~w_int_mask;
    assign w_buf_sel   = r_buf[w_tx_vc];

`ifdef HOP_UPDATE_EN
    // One hop consumed per traversal: hop field shifted right by one on the way out.
    always_comb begin
        w_tx_data = w_buf_sel;
        w_tx_data[HOP_LSB +: HOP_W] = w_buf_sel[HOP_LSB +: HOP_W] >> 1;
    end
`else
    assign w_tx_data = w_buf_sel;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < 2; v++) begin
                r_buf[v] <= '0;
            end
            r_full <= 2'b00;
            r_so   <= 1'b0;
            r_do   <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (w_acc[v]) begin
                    r_buf[v] <= d_in;
                end
            end
            r_full <= (r_full | w_acc) & ~w_send_mask;
            r_so   <= w_send;
            if (w_send) begin
                r_do  <= w_tx_data;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign full    = r_full;
    assign link_so = r_so;
    assign link_do = r_do;
    assign err_ovf = r_err;
    assign tx_cnt  = r_cnt;

endmodule

// File: tb/tb_outport_link_tx.sv
// Directed scoreboard bench for outport_link_tx; a second instance with a 4-bit counter covers wrap.
module tb_outport_link_tx;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              polarity;
    logic [1:0]        enq;
    logic [DATA_W-1:0] d_in;
    logic              link_ri;
    logic [1:0]        full;
    logic              link_so;
    logic [DATA_W-1:0] link_do;
    logic              err_ovf;
    logic [CNT_W-1:0]  tx_cnt;
    logic [1:0]        wr_full;
    logic              wr_so;
    logic [DATA_W-1:0] wr_do;
    logic              wr_err;
    logic [3:0]        wr_cnt;

    int unsigned       n_pass = 0;
    int unsigned       n_tot  = 0;
    int unsigned       model_cnt = 0;
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];

    outport_link_tx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset), .polarity(polarity), .enq(enq), .d_in(d_in),
        .full(full), .link_ri(link_ri), .link_so(link_so), .link_do(link_do),
        .err_ovf(err_ovf), .tx_cnt(tx_cnt)
    );

    outport_link_tx #(.DATA_W(DATA_W), .CNT_W(4)) u_wrap (
        .clk(clk), .reset(reset), .polarity(polarity), .enq(enq), .d_in(d_in),
        .full(wr_full), .link_ri(link_ri), .link_so(wr_so), .link_do(wr_do),
        .err_ovf(wr_err), .tx_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] exp_out(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
`ifdef HOP_UPDATE_EN
        r[55:48] = d[55:48] >> 1;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    endtask

    task automatic chk_state(input logic [1:0] f, input logic e);
        chk("full", 64'(full), 64'(f));
        chk("err_ovf", 64'(err_ovf), 64'(e));
        chk("wrap_full", 64'(wr_full), 64'(f));
        chk("wrap_err", 64'(wr_err), 64'(e));
    endtask

    // Drive a legal enqueue and record the expected link word for that VC.
    task automatic put(input logic vc, input logic [DATA_W-1:0] d);
        polarity = vc;
        enq      = vc ? 2'b10 : 2'b01;
        d_in     = d;
        if (vc) q1.push_back(exp_out(d));
        else    q0.push_back(exp_out(d));
    endtask

    // One clock; any send is popped from the sent VC's queue and compared.
    task automatic tick();
        logic pol_e;
        logic [DATA_W-1:0] e;
        @(posedge clk);
        pol_e = polarity;
        #1;
        if (link_so) begin
            if ((pol_e ? q0.size() : q1.size()) == 0) begin
                chk("spurious_send", 64'(link_so), 64'd0);
            end else begin
                e = pol_e ? q0.pop_front() : q1.pop_front();
                chk(pol_e ? "link_do_vc0" : "link_do_vc1", link_do, e);
                chk("wrap_so", 64'(wr_so), 64'd1);
                chk("wrap_do", wr_do, e);
            end
            model_cnt++;
        end
        chk("tx_cnt", 64'(tx_cnt), 64'(model_cnt % 65536));
        chk("wrap_cnt", 64'(wr_cnt), 64'(model_cnt % 16));
    endtask

    initial begin
        reset = 1'b1; polarity = 1'b0; enq = 2'b00; d_in = '0; link_ri = 1'b0;
        #1;
        chk_state(2'b00, 1'b0);
        chk("so_reset", 64'(link_so), 64'd0);
        chk("do_reset", link_do, 64'd0);
        chk("cnt_reset", 64'(tx_cnt), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single VC0 packet: accepted at pol=0 edge, sent at next pol=1 edge.
        link_ri = 1'b1;
        put(1'b0, 64'hA5A5_0000_0000_1234);
        tick();
        chk_state(2'b01, 1'b0);
        chk("so_before_send", 64'(link_so), 64'd0);
        enq = 2'b00; polarity = 1'b1;
        tick();
        chk("so_vc0_send", 64'(link_so), 64'd1);
        chk_state(2'b00, 1'b0);
        chk("cnt_after_1", 64'(tx_cnt), 64'd1);

        // VC1 blocked for two external phases, then sent exactly once.
        link_ri = 1'b0;
        put(1'b1, 64'hD1D1_2222_3333_4444);
        tick();
        enq = 2'b00;
        for (int i = 0; i < 2; i++) begin
            polarity = 1'b0; tick();
            chk("so_blocked", 64'(link_so), 64'd0);
            chk_state(2'b10, 1'b0);
            polarity = 1'b1; tick();
        end
        polarity = 1'b0; link_ri = 1'b1;
        tick();
        chk("so_vc1_release", 64'(link_so), 64'd1);
        chk("cnt_after_2", 64'(tx_cnt), 64'd2);
        polarity = 1'b1; tick();
        polarity = 1'b0; tick();
        chk("so_no_dup", 64'(link_so), 64'd0);
        chk_state(2'b00, 1'b0);

        // Back-to-back alternating VCs.
        put(1'b0, 64'h0000_0000_0000_00A0); tick();
        put(1'b1, 64'h0000_0000_0000_00B1); tick();
        chk("b2b_so1", 64'(link_so), 64'd1);
        put(1'b0, 64'h0000_0000_0000_00C0); tick();
        chk("b2b_so2", 64'(link_so), 64'd1);
        put(1'b1, 64'h0000_0000_0000_00D1); tick();
        chk("b2b_so3", 64'(link_so), 64'd1);
        enq = 2'b00; polarity = 1'b0; tick();
        chk("b2b_so4", 64'(link_so), 64'd1);
        chk("cnt_after_b2b", 64'(tx_cnt), 64'd6);
        chk("b2b_q_empty", 64'(q0.size() + q1.size()), 64'd0);

        // Overflow and wrong-phase enqueue: buffer keeps original data, err sticky.
        link_ri = 1'b0;
        put(1'b0, 64'h0000_0000_0000_00E0); tick();
        chk_state(2'b01, 1'b0);
        polarity = 1'b0; enq = 2'b01; d_in = 64'hBAD0_BAD0_BAD0_BAD0; tick();
        chk_state(2'b01, 1'b1);
        polarity = 1'b0; enq = 2'b10; d_in = 64'hBAD1_BAD1_BAD1_BAD1; tick();
        chk_state(2'b01, 1'b1);
        polarity = 1'b1; enq = 2'b11; d_in = 64'h0000_0000_0000_00F1;
        q1.push_back(exp_out(d_in));
        tick();
        chk_state(2'b11, 1'b1);
        enq = 2'b00; link_ri = 1'b1;
        polarity = 1'b0; tick();
        polarity = 1'b1; tick();
        chk_state(2'b00, 1'b1);
        chk("cnt_after_err", 64'(tx_cnt), 64'd8);

        // Hop field handling.
        put(1'b0, 64'h120C_3456_789A_BCDE); tick();
        enq = 2'b00; polarity = 1'b1; tick();
`ifdef HOP_UPDATE_EN
        chk("hop_field", 64'(link_do[55:48]), 64'h06);
`else
        chk("hop_field", 64'(link_do[55:48]), 64'h0C);
`endif
        chk("hop_other_hi", 64'(link_do[63:56]), 64'h12);
        chk("hop_other_lo", 64'(link_do[47:0]), 64'h3456_789A_BCDE);

        // Pipelined traffic up to 16 packets: 4-bit counter wraps to zero.
        for (int i = 0; i < 7; i++) begin
            put(1'(i % 2), {32'($urandom), 32'($urandom)});
            tick();
        end
        enq = 2'b00; polarity = ~polarity; tick();
        chk("wrap_cnt_zero", 64'(wr_cnt), 64'd0);
        chk("cnt_16", 64'(tx_cnt), 64'd16);
        chk("final_q_empty", 64'(q0.size() + q1.size()), 64'd0);

        // Async reset mid-cycle with both buffers full.
        link_ri = 1'b0;
        put(1'b0, 64'h1111); tick();
        put(1'b1, 64'h2222); tick();
        enq = 2'b00;
        chk_state(2'b11, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_state(2'b00, 1'b0);
        chk("so_async_rst", 64'(link_so), 64'd0);
        chk("cnt_async_rst", 64'(tx_cnt), 64'd0);
        chk("wrap_cnt_async_rst", 64'(wr_cnt), 64'd0);
        q0.delete(); q1.delete(); model_cnt = 0;
        @(posedge clk); #1;
        reset = 1'b0; link_ri = 1'b1; polarity = 1'b1;
        tick();
        chk("no_send_after_rst", 64'(link_so), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
